// File: rtl/result_uart_pkg.sv
// Shared constants, FSM encoding and sizing helper for the result UART reporter.
package result_uart_pkg;

  localparam logic [7:0] CMD_RESEND = 8'h52;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Wide enough for the longest hex report (64-bit result plus CR/LF).
  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACC,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

  function automatic int unsigned nbytes(input int unsigned data_w);
    return (data_w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/result_uart_reporter_hex.sv
// Maps one 4-bit nibble to its uppercase ASCII hex character.
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  always_comb begin
    if (nibble < 4'd10) ascii_c = 8'h30 + 8'(nibble);
    else                ascii_c = 8'h37 + 8'(nibble);
  end

endmodule

// File: rtl/result_uart_reporter.sv
// Snapshots an engine result when it stops running and streams it to a UART
// as raw bytes or ASCII hex, with host-requested resend via 'R'.
module result_uart_reporter
  import result_uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HEX_MODE    = 0,
  parameter int unsigned APPEND_CRLF = 1,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] result,
  input  logic              running,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              reporting,
  output logic              report_done
);

  localparam int unsigned NBYTES   = nbytes(DATA_W);
  localparam int unsigned SHADOW_W = 8 * NBYTES;
  localparam int unsigned NNIB     = 2 * NBYTES;
  localparam int unsigned LAST     = (HEX_MODE != 0) ?
                                     ((APPEND_CRLF != 0) ? NNIB + 1 : NNIB - 1) :
                                     NBYTES - 1;

  state_t              state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                armed_q, resend_pend_q;
  logic                go_c, last_c, snapshot_c;
  logic                tx_start_d, reporting_d, report_done_d;
  logic [7:0]          tx_byte_d, raw_byte_c, byte_sel_c, ascii_c;
  logic [3:0]          nibble_c;
  int unsigned         idx_int, raw_pos, nib_pos;

  assign go_c   = !running && (armed_q || resend_pend_q);
  assign last_c = (idx_int == LAST);

  // Byte/nibble mux over the shadow register, ordered by MSB_FIRST; CR/LF trail the digits.
  always_comb begin
    idx_int    = 32'(idx_q);
    raw_pos    = 0;
    nib_pos    = 0;
    raw_byte_c = '0;
    nibble_c   = '0;
    if (idx_int < NBYTES) raw_pos = (MSB_FIRST != 0) ? NBYTES - 1 - idx_int : idx_int;
    if (idx_int < NNIB)   nib_pos = (MSB_FIRST != 0) ? NNIB - 1 - idx_int : idx_int;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (raw_pos == i) raw_byte_c = shadow_q[8*i +: 8];
    for (int unsigned i = 0; i < NNIB; i++)
      if (nib_pos == i) nibble_c = shadow_q[4*i +: 4];
  end

  hex_nibble_to_ascii u_hex (
    .nibble  (nibble_c),
    .ascii_c (ascii_c)
  );

  always_comb begin
    byte_sel_c = raw_byte_c;
    if (HEX_MODE != 0) begin
      if (idx_int < NNIB)       byte_sel_c = ascii_c;
      else if (idx_int == NNIB) byte_sel_c = ASCII_CR;
      else                      byte_sel_c = ASCII_LF;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (go_c)     state_d = ST_SEND;
      ST_SEND:      if (!tx_busy) state_d = ST_WAIT_ACC;
      ST_WAIT_ACC:  if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = last_c ? ST_FINISH : ST_SEND;
      ST_FINISH:                  state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    tx_start_d    = 1'b0;
    tx_byte_d     = tx_byte;
    report_done_d = 1'b0;
    idx_d         = idx_q;
    snapshot_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          snapshot_c = 1'b1;
          idx_d      = '0;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = byte_sel_c;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy && !last_c) idx_d = idx_q + IDX_W'(1);
      end
      ST_FINISH: report_done_d = 1'b1;
      default: ;
    endcase
    reporting_d = (state_d != ST_IDLE);
  end

  // Registered outputs, snapshot and request flags; a new 'R' wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= '0;
      idx_q         <= '0;
      armed_q       <= 1'b1;
      resend_pend_q <= 1'b0;
      tx_start      <= 1'b0;
      tx_byte       <= 8'h00;
      reporting     <= 1'b0;
      report_done   <= 1'b0;
    end else begin
      if (snapshot_c) shadow_q <= SHADOW_W'(result);
      idx_q       <= idx_d;
      tx_start    <= tx_start_d;
      tx_byte     <= tx_byte_d;
      reporting   <= reporting_d;
      report_done <= report_done_d;
      if (running)         armed_q <= 1'b1;
      else if (snapshot_c) armed_q <= 1'b0;
      if (rx_valid && (rx_byte == CMD_RESEND)) resend_pend_q <= 1'b1;
      else if (snapshot_c)                      resend_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_uart_reporter.sv
// Scoreboard bench: three reporter configurations share stimulus, each with its own UART model.
module tb_result_uart_reporter;

  localparam int NI = 3;
  localparam logic [7:0] R_CMD = 8'h52;

  logic        clk = 1'b0;
  logic        reset;
  logic        running;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [63:0] res;

  logic        tx_start    [NI];
  logic [7:0]  tx_byte     [NI];
  logic        tx_busy     [NI] = '{default: 1'b0};
  logic        reporting   [NI];
  logic        report_done [NI];

  logic [7:0]  exp_q [NI][$];
  int          exp_done  [NI] = '{default: 0};
  int          done_cnt  [NI] = '{default: 0};
  int          pend      [NI] = '{default: 0};
  int          busy_cnt  [NI] = '{default: 0};
  logic [7:0]  held_byte [NI] = '{default: 8'h00};
  logic        prev_start[NI] = '{default: 1'b0};
  bit          flushing = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  result_uart_reporter #(.DATA_W(16), .HEX_MODE(0), .APPEND_CRLF(1), .MSB_FIRST(1)) dut_raw16 (
    .clk(clk), .reset(reset), .result(res[15:0]), .running(running), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_byte(tx_byte[0]),
    .reporting(reporting[0]), .report_done(report_done[0]));

  result_uart_reporter #(.DATA_W(12), .HEX_MODE(1), .APPEND_CRLF(1), .MSB_FIRST(1)) dut_hex12 (
    .clk(clk), .reset(reset), .result(res[11:0]), .running(running), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_byte(tx_byte[1]),
    .reporting(reporting[1]), .report_done(report_done[1]));

  result_uart_reporter #(.DATA_W(24), .HEX_MODE(0), .APPEND_CRLF(1), .MSB_FIRST(0)) dut_raw24 (
    .clk(clk), .reset(reset), .result(res[23:0]), .running(running), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_busy(tx_busy[2]), .tx_start(tx_start[2]), .tx_byte(tx_byte[2]),
    .reporting(reporting[2]), .report_done(report_done[2]));

  function automatic int cfg_w(input int k);
    case (k)
      0:       return 16;
      1:       return 12;
      default: return 24;
    endcase
  endfunction

  function automatic bit cfg_hex(input int k);
    return k == 1;
  endfunction

  function automatic bit cfg_msb(input int k);
    return k != 2;
  endfunction

  function automatic void check(input string name, input int k, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endfunction

  // Reference encoding of one report straight from the format rules.
  task automatic push_report(input int k, input logic [63:0] v);
    int w; int nb; int pos;
    logic [63:0] m;
    logic [3:0]  nib;
    w  = cfg_w(k);
    nb = (w + 7) / 8;
    m  = v & ((64'd1 << w) - 64'd1);
    if (cfg_hex(k)) begin
      for (int d = 0; d < 2 * nb; d++) begin
        pos = cfg_msb(k) ? 2 * nb - 1 - d : d;
        nib = 4'(m >> (4 * pos));
        exp_q[k].push_back((nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
      end
      exp_q[k].push_back(8'h0D);
      exp_q[k].push_back(8'h0A);
    end else begin
      for (int d = 0; d < nb; d++) begin
        pos = cfg_msb(k) ? nb - 1 - d : d;
        exp_q[k].push_back(8'(m >> (8 * pos)));
      end
    end
    exp_done[k]++;
  endtask

  task automatic push_all(input logic [63:0] v);
    for (int k = 0; k < NI; k++) push_report(k, v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_engine(input logic [63:0] v, input int hi);
    running = 1'b1;
    res     = v;
    tick(hi);
    push_all(v);
    running = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (b == R_CMD) push_all(res);
    tick(1);
    rx_valid = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < NI; k++)
      if (exp_q[k].size() != 0 || reporting[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (t < 3000 && !all_idle()) begin
      tick(1);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle_%s: reports still outstanding after %0d cycles", tag, t);
    end
  endtask

  // Monitor and UART model: check each start against the scoreboard, then advance the UART.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!flushing) begin
        if (tx_start[k]) begin
          check("start_gap", k, 64'(prev_start[k]), 64'd0);
          check("start_while_busy", k, 64'(tx_busy[k]), 64'd0);
          check("reporting_on_start", k, 64'(reporting[k]), 64'd1);
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte inst%0d: got %02h with nothing expected at %0t",
                     k, tx_byte[k], $time);
          end else begin
            check("tx_byte", k, 64'(tx_byte[k]), 64'(exp_q[k].pop_front()));
          end
        end else if (pend[k] > 0 || busy_cnt[k] > 0) begin
          check("tx_byte_hold", k, 64'(tx_byte[k]), 64'(held_byte[k]));
        end
        if (report_done[k]) done_cnt[k]++;
      end
      prev_start[k] = tx_start[k];
      if (tx_start[k]) begin
        pend[k]      = $urandom_range(1, 3);
        held_byte[k] = tx_byte[k];
      end else if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          tx_busy[k]  = 1'b1;
          busy_cnt[k] = $urandom_range(1, 5);
        end
      end else if (busy_cnt[k] > 0) begin
        busy_cnt[k]--;
        if (busy_cnt[k] == 0) tx_busy[k] = 1'b0;
      end
      if (flushing) held_byte[k] = 8'h00;
    end
  end

  initial begin
    int t;
    logic [63:0] v;
    logic [7:0]  b;
    reset    = 1'b1;
    running  = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    res      = 64'h0;
    tick(3);
    for (int k = 0; k < NI; k++) begin
      check("rst_tx_start", k, 64'(tx_start[k]), 64'd0);
      check("rst_tx_byte", k, 64'(tx_byte[k]), 64'd0);
      check("rst_reporting", k, 64'(reporting[k]), 64'd0);
      check("rst_report_done", k, 64'(report_done[k]), 64'd0);
    end
    reset = 1'b0;
    tick(2);

    // Basic report with snapshot and first-start latency.
    run_engine(64'hA55A, 2);
    tick(1);
    check("snapshot_latency", 0, 64'(reporting[0]), 64'd1);
    tick(1);
    check("first_start", 0, 64'(tx_start[0]), 64'd1);
    wait_idle("a55a");
    tick(30);

    run_engine(64'h3F7, 3);
    wait_idle("3f7");
    run_engine(64'h123456, 1);
    wait_idle("123456");

    // Only 'R' triggers a resend of the current result.
    send_rx(8'h41);
    tick(3);
    send_rx(R_CMD);
    wait_idle("resend");

    // 'R' during a report gives exactly one extra report.
    run_engine(64'h00BEEF, 2);
    tick(3);
    send_rx(R_CMD);
    wait_idle("mid_r");

    // Engine restarts mid-report with a new result.
    run_engine(64'hA55A, 2);
    t = 0;
    while (t < 100 && !tx_start[0]) begin
      tick(1);
      t++;
    end
    check("first_byte_seen", 0, 64'(t < 100), 64'd1);
    res     = 64'hFFFF;
    running = 1'b1;
    tick(2);
    push_all(64'hFFFF);
    running = 1'b0;
    wait_idle("rerun");

    // Armed and resend both pending collapse into one report.
    running = 1'b1;
    res     = 64'h5A5A5A;
    tick(1);
    send_rx(R_CMD);
    tick(1);
    running = 1'b0;
    wait_idle("armed_and_r");

    // Reset while waiting for the UART to finish a byte.
    run_engine(64'h13579B, 2);
    t = 0;
    while (t < 100 && !tx_busy[0]) begin
      tick(1);
      t++;
    end
    check("busy_before_reset", 0, 64'(tx_busy[0]), 64'd1);
    busy_cnt[0] = 20;
    flushing    = 1'b1;
    reset       = 1'b1;
    tick(1);
    for (int k = 0; k < NI; k++) begin
      check("midrst_tx_start", k, 64'(tx_start[k]), 64'd0);
      check("midrst_tx_byte", k, 64'(tx_byte[k]), 64'd0);
      check("midrst_reporting", k, 64'(reporting[k]), 64'd0);
      check("midrst_report_done", k, 64'(report_done[k]), 64'd0);
      exp_q[k].delete();
      exp_done[k]--;
    end
    reset = 1'b0;
    push_all(res);
    flushing = 1'b0;
    tick(3);
    check("hold_while_busy", 0, 64'(tx_start[0]), 64'd0);
    check("reporting_after_rst", 0, 64'(reporting[0]), 64'd1);
    wait_idle("after_reset");

    // Randomised mix of engine runs, host bytes and mid-report resends.
    for (int i = 0; i < 25; i++) begin
      v = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0, 1: run_engine(v, $urandom_range(1, 6));
        2: begin
          b = 8'($urandom_range(0, 255));
          if (i % 3 == 0) b = R_CMD;
          send_rx(b);
        end
        default: begin
          run_engine(v, $urandom_range(1, 4));
          tick($urandom_range(2, 4));
          send_rx(R_CMD);
        end
      endcase
      wait_idle("random");
      tick($urandom_range(0, 5));
    end
    tick(20);

    for (int k = 0; k < NI; k++) begin
      check("queue_drained", k, 64'(exp_q[k].size()), 64'd0);
      check("report_done_count", k, 64'(done_cnt[k]), 64'(exp_done[k]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
